// File: rtl/vga_timing_pkg.sv
// 640x480@60 raster timing constants and shared counter type for the VGA timing generator.
package vga_timing_pkg;

    localparam int unsigned CntW    = 10;

    localparam int unsigned HActive = 640;
    localparam int unsigned HFp     = 16;
    localparam int unsigned HSync   = 96;
    localparam int unsigned HBp     = 48;
    localparam int unsigned HTotal  = HActive + HFp + HSync + HBp;

    localparam int unsigned VActive = 480;
    localparam int unsigned VFp     = 10;
    localparam int unsigned VSync   = 2;
    localparam int unsigned VBp     = 33;
    localparam int unsigned VTotal  = VActive + VFp + VSync + VBp;

    typedef logic [CntW-1:0] cnt_t;

    // True when c lies in [start, start+len-1].
    function automatic logic in_window(input cnt_t c, input int unsigned start,
                                       input int unsigned len);
        return (32'(c) >= start) && (32'(c) < start + len);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Free-running divider producing a one-clock strobe every CLK_DIV clocks.
module pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en
);

    localparam int unsigned DivW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q, div_d;

    assign pix_en = (div_q == DivLast);

    always_comb begin
        div_d = div_q + 1'b1;
        if (pix_en) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing on a pixel clock-enable: h/v counters, sync decode and an aligned
// output register stage for colour and syncs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = HActive,
    parameter int unsigned H_FP     = HFp,
    parameter int unsigned H_SYNC   = HSync,
    parameter int unsigned H_BP     = HBp,
    parameter int unsigned V_ACTIVE = VActive,
    parameter int unsigned V_FP     = VFp,
    parameter int unsigned V_SYNC   = VSync,
    parameter int unsigned V_BP     = VBp,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            pix_en,
    output logic [CntW-1:0] hcount,
    output logic [CntW-1:0] vcount,
    output logic            video_on,
    output logic            line_start,
    output logic            frame_start,
    input  logic [7:0]      rgb_in,
    output logic [7:0]      rgb_out,
    output logic            hsync,
    output logic            vsync
);

    localparam int unsigned HTot  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTot  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam cnt_t        HLast = cnt_t'(HTot - 1);
    localparam cnt_t        VLast = cnt_t'(VTot - 1);

    cnt_t       h_q, h_d;
    cnt_t       v_q, v_d;
    logic       h_win, v_win;
    logic [7:0] rgb_q;
    logic       hsync_q, vsync_q;

    pixel_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .pix_en(pix_en)
    );

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en) begin
            if (h_q == HLast) begin
                h_d = '0;
                v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign video_on    = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    assign h_win       = in_window(h_q, H_ACTIVE + H_FP, H_SYNC);
    assign v_win       = in_window(v_q, V_ACTIVE + V_FP, V_SYNC);
    assign line_start  = pix_en && (h_q == '0);
    assign frame_start = line_start && (v_q == '0);

    // Colour and syncs are sampled from the same counter state so they leave aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q   <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
        end else if (pix_en) begin
            rgb_q   <= video_on ? rgb_in : '0;
            hsync_q <= h_win ? SYNC_POL : ~SYNC_POL;
            vsync_q <= v_win ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign hcount  = h_q;
    assign vcount  = v_q;
    assign rgb_out = rgb_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: standard timing at CLK_DIV 2 and 4, plus a shrunken raster
// so frame wrap, vsync and a mid-sync asynchronous reset fit in a short run.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pe;
        logic [9:0] h;
        logic [9:0] v;
        logic       vo;
        logic       ls;
        logic       fs;
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
    } exp_t;

    typedef struct {
        int         k;
        int         inst;
        logic       pe;
        logic [9:0] h;
        logic [9:0] v;
        logic       vo;
        logic       ls;
        logic       fs;
        logic       hs;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rgb_in;

    logic       pe  [3];
    logic [9:0] hc  [3];
    logic [9:0] vc  [3];
    logic       vo  [3];
    logic       ls  [3];
    logic       fs  [3];
    logic [7:0] rgb [3];
    logic       hs  [3];
    logic       vs  [3];

    // Instance timing: 0 = standard /2, 1 = standard /4, 2 = small raster /2.
    int c_div [3] = '{2, 4, 2};
    int c_ha  [3] = '{640, 640, 8};
    int c_hfp [3] = '{16, 16, 2};
    int c_hs  [3] = '{96, 96, 3};
    int c_hbp [3] = '{48, 48, 2};
    int c_va  [3] = '{480, 480, 6};
    int c_vfp [3] = '{10, 10, 1};
    int c_vs  [3] = '{2, 2, 2};
    int c_vbp [3] = '{33, 33, 1};

    int   vectors     = 0;
    int   miscompares = 0;
    int   k           = 0;
    exp_t sb[$];

    bit count_en = 1'b0;
    int fs_cnt   = 0;
    int ls_cnt   = 0;
    int hs_low   = 0;
    int vs_low   = 0;
    int ls4_n    = 0;
    int ls4_k0   = 0;
    int ls4_k1   = 0;

    always #10 clk = ~clk;

    vga_timing_gen u_std (
        .clk(clk), .rst_n(rst_n), .pix_en(pe[0]), .hcount(hc[0]), .vcount(vc[0]),
        .video_on(vo[0]), .line_start(ls[0]), .frame_start(fs[0]), .rgb_in(rgb_in),
        .rgb_out(rgb[0]), .hsync(hs[0]), .vsync(vs[0])
    );

    vga_timing_gen #(
        .CLK_DIV(4)
    ) u_div4 (
        .clk(clk), .rst_n(rst_n), .pix_en(pe[1]), .hcount(hc[1]), .vcount(vc[1]),
        .video_on(vo[1]), .line_start(ls[1]), .frame_start(fs[1]), .rgb_in(rgb_in),
        .rgb_out(rgb[1]), .hsync(hs[1]), .vsync(vs[1])
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .pix_en(pe[2]), .hcount(hc[2]), .vcount(vc[2]),
        .video_on(vo[2]), .line_start(ls[2]), .frame_start(fs[2]), .rgb_in(rgb_in),
        .rgb_out(rgb[2]), .hsync(hs[2]), .vsync(vs[2])
    );

    // Colour driven during the clock that follows edge kk; differs on every cycle so a
    // sample taken on the wrong cycle shows up.
    function automatic logic [7:0] rgb_of(input int kk);
        return 8'((kk * 29 + (kk >> 4) * 7 + 3) & 255);
    endfunction

    // Closed-form expected outputs kk clock edges after reset release.
    function automatic exp_t model(input int i, input int kk);
        exp_t e;
        int   n, p, ht, vt, h, v, ph, pv, hs0, vs0;
        ht   = c_ha[i] + c_hfp[i] + c_hs[i] + c_hbp[i];
        vt   = c_va[i] + c_vfp[i] + c_vs[i] + c_vbp[i];
        hs0  = c_ha[i] + c_hfp[i];
        vs0  = c_va[i] + c_vfp[i];
        n    = kk / c_div[i];
        h    = n % ht;
        v    = (n / ht) % vt;
        e.pe = (kk % c_div[i]) == c_div[i] - 1;
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.vo = (h < c_ha[i]) && (v < c_va[i]);
        e.ls = e.pe && (h == 0);
        e.fs = e.ls && (v == 0);
        if (n == 0) begin
            e.rgb = 8'h00;
            e.hs  = 1'b1;
            e.vs  = 1'b1;
        end else begin
            p     = n - 1;
            ph    = p % ht;
            pv    = (p / ht) % vt;
            e.rgb = (ph < c_ha[i] && pv < c_va[i]) ? rgb_of(p * c_div[i] + c_div[i] - 1)
                                                   : 8'h00;
            e.hs  = !(ph >= hs0 && ph < hs0 + c_hs[i]);
            e.vs  = !(pv >= vs0 && pv < vs0 + c_vs[i]);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic cmp_rec(input int i, input exp_t e, input string tag);
        chk($sformatf("%s u%0d pix_en", tag, i),      32'(pe[i]),  32'(e.pe));
        chk($sformatf("%s u%0d hcount", tag, i),      32'(hc[i]),  32'(e.h));
        chk($sformatf("%s u%0d vcount", tag, i),      32'(vc[i]),  32'(e.v));
        chk($sformatf("%s u%0d video_on", tag, i),    32'(vo[i]),  32'(e.vo));
        chk($sformatf("%s u%0d line_start", tag, i),  32'(ls[i]),  32'(e.ls));
        chk($sformatf("%s u%0d frame_start", tag, i), 32'(fs[i]),  32'(e.fs));
        chk($sformatf("%s u%0d rgb_out", tag, i),     32'(rgb[i]), 32'(e.rgb));
        chk($sformatf("%s u%0d hsync", tag, i),       32'(hs[i]),  32'(e.hs));
        chk($sformatf("%s u%0d vsync", tag, i),       32'(vs[i]),  32'(e.vs));
    endtask

    task automatic chk_reset(input string tag);
        for (int i = 0; i < 3; i++) cmp_rec(i, model(i, 0), tag);
        sb.delete();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        k      = 0;
        rgb_in = rgb_of(0);
        sb.delete();
        for (int i = 0; i < 3; i++) sb.push_back(model(i, 1));
    endtask

    // One clock: pop and compare this edge's expectations, drive, push the next edge's.
    task automatic step();
        exp_t e;
        @(posedge clk);
        k++;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (sb.size() == 0) begin
                chk($sformatf("scoreboard empty u%0d", i), 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                cmp_rec(i, e, "sb");
            end
        end
        if (count_en) begin
            if (fs[2]) fs_cnt++;
            if (ls[0]) ls_cnt++;
            if (k <= 1600 && !hs[0]) hs_low++;
            if (k <= 300 && !vs[2]) vs_low++;
            if (ls[1]) begin
                if (ls4_n == 0) ls4_k0 = k;
                else ls4_k1 = k;
                ls4_n++;
            end
        end
        rgb_in = rgb_of(k);
        for (int i = 0; i < 3; i++) sb.push_back(model(i, k + 1));
    endtask

    initial begin
        vec_t tbl [18];
        vec_t t;

        tbl[0]  = '{1,    0, 1'b1, 10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{1,    1, 1'b0, 10'd0,   10'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{2,    0, 1'b0, 10'd1,   10'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{3,    1, 1'b1, 10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{299,  2, 1'b1, 10'd14,  10'd9, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{300,  2, 1'b0, 10'd0,   10'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{301,  2, 1'b1, 10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{1279, 0, 1'b1, 10'd639, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1280, 0, 1'b0, 10'd640, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1313, 0, 1'b1, 10'd656, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1314, 0, 1'b0, 10'd657, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1505, 0, 1'b1, 10'd752, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1506, 0, 1'b0, 10'd753, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1599, 0, 1'b1, 10'd799, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1600, 0, 1'b0, 10'd0,   10'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1601, 0, 1'b1, 10'd0,   10'd1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[16] = '{3203, 1, 1'b1, 10'd0,   10'd1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[17] = '{3204, 1, 1'b0, 10'd1,   10'd1, 1'b1, 1'b0, 1'b0, 1'b1};

        rst_n  = 1'b0;
        rgb_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        release_reset();

        count_en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            while (k < tbl[i].k) step();
            t = tbl[i];
            chk($sformatf("tbl%0d pix_en", i),      32'(pe[t.inst]), 32'(t.pe));
            chk($sformatf("tbl%0d hcount", i),      32'(hc[t.inst]), 32'(t.h));
            chk($sformatf("tbl%0d vcount", i),      32'(vc[t.inst]), 32'(t.v));
            chk($sformatf("tbl%0d video_on", i),    32'(vo[t.inst]), 32'(t.vo));
            chk($sformatf("tbl%0d line_start", i),  32'(ls[t.inst]), 32'(t.ls));
            chk($sformatf("tbl%0d frame_start", i), 32'(fs[t.inst]), 32'(t.fs));
            chk($sformatf("tbl%0d hsync", i),       32'(hs[t.inst]), 32'(t.hs));
        end
        while (k < 3500) step();
        count_en = 1'b0;

        chk("small frame_start count", 32'(fs_cnt), 32'd12);
        chk("std line_start count", 32'(ls_cnt), 32'd3);
        chk("std hsync low clocks", 32'(hs_low), 32'd192);
        chk("small vsync low clocks", 32'(vs_low), 32'd60);
        chk("div4 line_start count", 32'(ls4_n), 32'd2);
        chk("div4 line period clks", 32'(ls4_k1 - ls4_k0), 32'd3200);

        // Fresh start, then drop reset mid-cycle while the small raster sits in h and v sync.
        #2 rst_n = 1'b0;
        #1 chk_reset("rst2");
        repeat (2) @(posedge clk);
        release_reset();
        while (k < 232) step();
        chk("pre-async small hcount", 32'(hc[2]), 32'd11);
        chk("pre-async small vcount", 32'(vc[2]), 32'd7);
        chk("pre-async small hsync", 32'(hs[2]), 32'd0);
        chk("pre-async small vsync", 32'(vs[2]), 32'd0);
        #4 rst_n = 1'b0;
        #1 chk_reset("async");
        repeat (3) @(posedge clk);
        #1 chk_reset("async hold");
        release_reset();
        while (k < 400) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
